// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with a valid/ready handshake and synchronous flush.
// With SKID=1, a second entry absorbs one beat so that in_ready can come straight from a flop.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SKID      = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   // Each encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      MAIN  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           stateQ, stateD;
   logic [WIDTH-1:0] mainQ, mainD;
   logic [WIDTH-1:0] skidQ, skidD;
   logic             push, pop;

   assign out_valid = (stateQ != EMPTY);
   assign out_data  = mainQ;
   assign occupancy = stateQ;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateQ <= EMPTY;
         mainQ  <= RESET_VAL;
         skidQ  <= RESET_VAL;
      end else begin
         stateQ <= stateD;
         mainQ  <= mainD;
         skidQ  <= skidD;
      end
   end

   always_comb begin
      stateD = stateQ;
      mainD  = mainQ;
      skidD  = skidQ;
      if (flush) begin
         stateD = EMPTY;
         mainD  = RESET_VAL;
         skidD  = RESET_VAL;
      end else begin
         case (stateQ)
            EMPTY: begin
               if (push) begin
                  stateD = MAIN;
                  mainD  = in_data;
               end
            end
            MAIN: begin
               if (push && pop) begin
                  mainD = in_data;
               end else if (push && SKID) begin
                  stateD = FULL;
                  skidD  = in_data;
               end else if (pop) begin
                  stateD = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  stateD = MAIN;
                  mainD  = skidQ;
               end
            end
            default: begin
               stateD = EMPTY;
            end
         endcase
      end
   end

   // Skid mode predicts readiness from the next state, so out_ready never reaches in_ready combinationally.
   if (SKID) begin : g_skid
      logic inReadyQ;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            inReadyQ <= 1'b1;
         end else begin
            inReadyQ <= (stateD != FULL);
         end
      end

      assign in_ready = inReadyQ;
   end else begin : g_single
      assign in_ready = !out_valid || out_ready;
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance (A) and one single-entry instance (B).
// Expected values are hand-derived from the stage's state transitions.
module tb_pipe_stage_reg;

   localparam logic [31:0] RV_A = 32'h0BAD_F00D;
   localparam logic [31:0] RV_B = 32'h1234_5678;

   logic        clk;
   logic        resetN;

   logic        aFlush, aInValid, aInReady, aOutValid, aOutReady;
   logic [31:0] aInData, aOutData;
   logic [1:0]  aOccupancy;

   logic        bFlush, bInValid, bInReady, bOutValid, bOutReady;
   logic [31:0] bInData, bOutData;
   logic [1:0]  bOccupancy;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV_A), .SKID(1'b1)) dutA (
      .clk(clk), .reset_n(resetN), .flush(aFlush),
      .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
      .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
      .occupancy(aOccupancy)
   );

   pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV_B), .SKID(1'b0)) dutB (
      .clk(clk), .reset_n(resetN), .flush(bFlush),
      .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
      .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
      .occupancy(bOccupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit selB, input logic flush, input logic valid,
                                input logic [31:0] data, input logic ready);
      if (selB) begin
         bFlush = flush; bInValid = valid; bInData = data; bOutReady = ready;
      end else begin
         aFlush = flush; aInValid = valid; aInData = data; aOutReady = ready;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkA(input string tag, input logic valid, input logic [31:0] data,
                         input logic [1:0] occ, input logic ready);
      checkOutput({tag, ".a_out_valid"}, 32'(aOutValid), 32'(valid));
      checkOutput({tag, ".a_out_data"}, aOutData, data);
      checkOutput({tag, ".a_occupancy"}, 32'(aOccupancy), 32'(occ));
      checkOutput({tag, ".a_in_ready"}, 32'(aInReady), 32'(ready));
   endtask

   task automatic checkB(input string tag, input logic valid, input logic [31:0] data,
                         input logic [1:0] occ);
      checkOutput({tag, ".b_out_valid"}, 32'(bOutValid), 32'(valid));
      checkOutput({tag, ".b_out_data"}, bOutData, data);
      checkOutput({tag, ".b_occupancy"}, 32'(bOccupancy), 32'(occ));
   endtask

   initial begin
      resetN = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      tick();
      checkA("reset", 1'b0, RV_A, 2'd0, 1'b1);
      checkB("reset", 1'b0, RV_B, 2'd0);

      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      resetN = 1'b1;
      #1;
      checkOutput("release.a_in_ready", 32'(aInReady), 32'd1);
      checkOutput("release.b_in_ready", 32'(bInReady), 32'd1);
      tick();
      checkA("idle", 1'b0, RV_A, 2'd0, 1'b1);

      // Streaming through the skid stage: one beat per cycle, never more than one held.
      for (int v = 1; v <= 4; v++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 32'(v), 1'b1);
         tick();
         checkA($sformatf("stream%0d", v), 1'b1, 32'(v), 2'd1, 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkA("stream_drain", 1'b0, 32'd4, 2'd0, 1'b1);

      // Back-pressure: 10 and 11 fill the stage, 12 waits upstream.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd10, 1'b0);
      tick();
      checkA("bp_push10", 1'b1, 32'd10, 2'd1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd11, 1'b0);
      tick();
      checkA("bp_push11", 1'b1, 32'd10, 2'd2, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd12, 1'b0);
      tick();
      checkA("bp_hold12", 1'b1, 32'd10, 2'd2, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd12, 1'b1);
      tick();
      checkA("bp_pop10", 1'b1, 32'd11, 2'd1, 1'b1);
      tick();
      checkA("bp_pop11_push12", 1'b1, 32'd12, 2'd1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkA("bp_pop12", 1'b0, 32'd12, 2'd0, 1'b1);

      // Flush while full, with a simultaneous offer that must be dropped.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd7, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd8, 1'b0);
      tick();
      checkA("flush_pre", 1'b1, 32'd7, 2'd2, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'd9, 1'b0);
      tick();
      checkA("flush", 1'b0, RV_A, 2'd0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkA("flush_post", 1'b0, RV_A, 2'd0, 1'b1);

      // Asynchronous reset between edges while full.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd7, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd8, 1'b0);
      tick();
      checkA("areset_pre", 1'b1, 32'd7, 2'd2, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("areset.a_out_valid", 32'(aOutValid), 32'd0);
      checkOutput("areset.a_occupancy", 32'(aOccupancy), 32'd0);
      checkOutput("areset.a_out_data", aOutData, RV_A);
      tick();
      resetN = 1'b1;
      tick();
      checkA("areset_post", 1'b0, RV_A, 2'd0, 1'b1);

      // Single-entry stage: combinational in_ready and zero-bubble replace.
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd5, 1'b0);
      tick();
      checkB("b_push5", 1'b1, 32'd5, 2'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd6, 1'b0);
      #1;
      checkOutput("b_stall.in_ready", 32'(bInReady), 32'd0);
      tick();
      checkB("b_hold5", 1'b1, 32'd5, 2'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd6, 1'b1);
      #1;
      checkOutput("b_release.in_ready", 32'(bInReady), 32'd1);
      tick();
      checkB("b_replace6", 1'b1, 32'd6, 2'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkB("b_drain", 1'b0, 32'd6, 2'd0);

      applyStimulus(1'b1, 1'b0, 1'b1, 32'd3, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'd4, 1'b1);
      tick();
      checkB("b_flush", 1'b0, RV_B, 2'd0);
      checkOutput("b_flush.in_ready", 32'(bInReady), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkB("b_flush_post", 1'b0, RV_B, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
